// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and the saturating-increment helper for the forwarding/hazard unit
package fwd_pkg;
  typedef enum logic {FWD_RUN, FWD_HOLD} fwd_state_e;
  typedef enum logic [1:0] {SEL_RF, SEL_S5, SEL_S4} fwd_sel_e;
  function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int unsigned w);
    return (cnt == ({64{1'b1}} >> (64 - w))) ? cnt : cnt + 64'd1;
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: pipeline-side signals of the S3 forwarding/hazard unit
interface fwd_hazard_unit_if #(
  parameter int BITS = 32,
  parameter int REG_WORDS = 32,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(REG_WORDS);
  logic                    valid_s3;
  logic [NUM_SRC-1:0]      src_used_s3;
  logic [NUM_SRC*AW-1:0]   src_addr_s3;
  logic [NUM_SRC*BITS-1:0] src_data_s3;
  logic                    valid_s4;
  logic                    rw_s4;
  logic                    is_load_s4;
  logic [AW-1:0]           waddr_s4;
  logic [BITS-1:0]         alu_out_s4;
  logic                    valid_s5;
  logic                    rw_s5;
  logic [AW-1:0]           waddr_s5;
  logic [BITS-1:0]         wdata_s5;
  logic                    hold_ext;
  logic                    cnt_clr;
  logic [NUM_SRC*BITS-1:0] src_data_fwd;
  logic                    stall_s3;
  logic                    bubble_s4;
  logic [CNT_W-1:0]        load_use_cnt;
  logic [CNT_W-1:0]        fwd_cnt;
  modport master (
    output valid_s3, src_used_s3, src_addr_s3, src_data_s3, valid_s4, rw_s4, is_load_s4,
           waddr_s4, alu_out_s4, valid_s5, rw_s5, waddr_s5, wdata_s5, hold_ext, cnt_clr,
    input  src_data_fwd, stall_s3, bubble_s4, load_use_cnt, fwd_cnt
  );
  modport slave (
    input  valid_s3, src_used_s3, src_addr_s3, src_data_s3, valid_s4, rw_s4, is_load_s4,
           waddr_s4, alu_out_s4, valid_s5, rw_s5, waddr_s5, wdata_s5, hold_ext, cnt_clr,
    output src_data_fwd, stall_s3, bubble_s4, load_use_cnt, fwd_cnt
  );
endinterface

// File: rtl/fwd_src_mux.sv
// fwd_src_mux: per-source S4/S5 comparators, priority mux and freeze capture register
module fwd_src_mux import fwd_pkg::*; #(
  parameter int BITS = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            used,
  input  logic [AW-1:0]   addr,
  input  logic [BITS-1:0] rf_data,
  input  logic            valid_s4,
  input  logic            rw_s4,
  input  logic            is_load_s4,
  input  logic [AW-1:0]   waddr_s4,
  input  logic [BITS-1:0] alu_out_s4,
  input  logic            valid_s5,
  input  logic            rw_s5,
  input  logic [AW-1:0]   waddr_s5,
  input  logic [BITS-1:0] wdata_s5,
  input  logic            capture,
  input  logic            keep,
  input  logic            in_hold,
  output logic            hit4,
  output logic            fwd,
  output logic [BITS-1:0] value
);
  fwd_sel_e        sel;
  logic            hit5, cap_vld, cap_fwd;
  logic [BITS-1:0] live, cap_data;
  always_comb begin
    hit4 = valid_s4 & rw_s4 & (waddr_s4 != '0) & used & (addr == waddr_s4);
    hit5 = valid_s5 & rw_s5 & (waddr_s5 != '0) & used & (addr == waddr_s5);
    sel = hit4 ? SEL_S4 : hit5 ? SEL_S5 : SEL_RF;
    live = (sel == SEL_S4) ? alu_out_s4 : (sel == SEL_S5) ? wdata_s5 : rf_data;
    value = (in_hold & cap_vld) ? cap_data : live;
    fwd = (in_hold & cap_vld) ? cap_fwd : (sel != SEL_RF);
  end
  // a load-use source has no valid data yet, so it stays live through the freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld <= 1'b0;
      cap_fwd <= 1'b0;
      cap_data <= '0;
    end else if (capture) begin
      cap_vld <= ~(hit4 & is_load_s4);
      cap_fwd <= sel != SEL_RF;
      cap_data <= live;
    end else if (!keep) begin
      cap_vld <= 1'b0;
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: S3 operand forwarding, load-use stall/bubble, freeze capture and perf counters
module fwd_hazard_unit import fwd_pkg::*; #(
  parameter int BITS = 32,
  parameter int REG_WORDS = 32,
  parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  fwd_hazard_unit_if.slave bus
);
  localparam int AW = ADDR_LEFT + 1;
  fwd_state_e              state, state_nx;
  logic [NUM_SRC-1:0]      hit4, fwd;
  logic [NUM_SRC*BITS-1:0] fwd_data;
  logic                    load_use, capture, in_hold;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_mux #(.BITS(BITS), .AW(AW)) u_mux (
      .clk(clk), .rst(rst),
      .used(bus.src_used_s3[g]),
      .addr(bus.src_addr_s3[g*AW +: AW]),
      .rf_data(bus.src_data_s3[g*BITS +: BITS]),
      .valid_s4(bus.valid_s4), .rw_s4(bus.rw_s4), .is_load_s4(bus.is_load_s4),
      .waddr_s4(bus.waddr_s4), .alu_out_s4(bus.alu_out_s4),
      .valid_s5(bus.valid_s5), .rw_s5(bus.rw_s5),
      .waddr_s5(bus.waddr_s5), .wdata_s5(bus.wdata_s5),
      .capture(capture), .keep(bus.hold_ext), .in_hold(in_hold),
      .hit4(hit4[g]), .fwd(fwd[g]), .value(fwd_data[g*BITS +: BITS])
    );
  end
  assign bus.src_data_fwd = fwd_data;
  always_comb begin
    state_nx = bus.hold_ext ? FWD_HOLD : FWD_RUN;
    in_hold = state == FWD_HOLD;
    capture = (state == FWD_RUN) & bus.hold_ext;
    load_use = bus.valid_s3 & |(hit4 & {NUM_SRC{bus.is_load_s4}});
    bus.stall_s3 = load_use | bus.hold_ext;
    bus.bubble_s4 = load_use & ~bus.hold_ext;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FWD_RUN;
      bus.load_use_cnt <= '0;
      bus.fwd_cnt <= '0;
    end else begin
      state <= state_nx;
      if (bus.cnt_clr) begin
        bus.load_use_cnt <= '0;
        bus.fwd_cnt <= '0;
      end else begin
        if (bus.bubble_s4) bus.load_use_cnt <= CNT_W'(sat_inc(64'(bus.load_use_cnt), CNT_W));
        if (bus.valid_s3 & ~bus.stall_s3 & |fwd) bus.fwd_cnt <= CNT_W'(sat_inc(64'(bus.fwd_cnt), CNT_W));
      end
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scenarios plus randomized run against a behavioural model
module tb_fwd_hazard_unit;
  localparam int BITS = 32, NS = 2, AW = 5, CW = 4, CMAX = 15;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  fwd_hazard_unit_if #(.BITS(BITS), .REG_WORDS(32), .NUM_SRC(NS), .CNT_W(CW)) bus ();
  fwd_hazard_unit #(.BITS(BITS), .REG_WORDS(32), .NUM_SRC(NS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int n_cmp = 0, n_bad = 0;
  logic [NS*BITS-1:0] exp_fwd;
  bit exp_stall, exp_bubble, exp_any;
  bit m_hold;
  bit m_cv[NS];
  bit m_cf[NS];
  logic [BITS-1:0] m_cd[NS];
  int m_lu, m_fc;
  task automatic idle();
    rst = 0;
    bus.valid_s3 = 0; bus.src_used_s3 = '0; bus.src_addr_s3 = '0; bus.src_data_s3 = '0;
    bus.valid_s4 = 0; bus.rw_s4 = 0; bus.is_load_s4 = 0; bus.waddr_s4 = '0; bus.alu_out_s4 = '0;
    bus.valid_s5 = 0; bus.rw_s5 = 0; bus.waddr_s5 = '0; bus.wdata_s5 = '0;
    bus.hold_ext = 0; bus.cnt_clr = 0;
  endtask
  task automatic set_src(input int k, input logic [AW-1:0] a, input logic [BITS-1:0] d);
    bus.src_used_s3[k] = 1'b1;
    bus.src_addr_s3[k*AW +: AW] = a;
    bus.src_data_s3[k*BITS +: BITS] = d;
  endtask
  task automatic s4(input logic v, input logic ld, input logic [AW-1:0] a, input logic [BITS-1:0] d);
    bus.valid_s4 = v; bus.rw_s4 = 1'b1; bus.is_load_s4 = ld; bus.waddr_s4 = a; bus.alu_out_s4 = d;
  endtask
  task automatic s5(input logic v, input logic [AW-1:0] a, input logic [BITS-1:0] d);
    bus.valid_s5 = v; bus.rw_s5 = 1'b1; bus.waddr_s5 = a; bus.wdata_s5 = d;
  endtask
  // youngest writer of a nonzero register supplies the operand
  task automatic src_eval(input int k, output logic [BITS-1:0] v, output bit fw, output bit h4);
    logic [AW-1:0] a;
    bit h5;
    a = bus.src_addr_s3[k*AW +: AW];
    h4 = bus.src_used_s3[k] && bus.valid_s4 && bus.rw_s4 && bus.waddr_s4 != 0 && a == bus.waddr_s4;
    h5 = bus.src_used_s3[k] && bus.valid_s5 && bus.rw_s5 && bus.waddr_s5 != 0 && a == bus.waddr_s5;
    v = h4 ? bus.alu_out_s4 : h5 ? bus.wdata_s5 : bus.src_data_s3[k*BITS +: BITS];
    fw = h4 || h5;
  endtask
  task automatic expect_now();
    logic [BITS-1:0] v;
    bit fw, h4, lu;
    lu = 0; exp_any = 0;
    for (int k = 0; k < NS; k++) begin
      src_eval(k, v, fw, h4);
      if (m_hold && m_cv[k]) begin
        exp_fwd[k*BITS +: BITS] = m_cd[k];
        exp_any |= m_cf[k];
      end else begin
        exp_fwd[k*BITS +: BITS] = v;
        exp_any |= fw;
      end
      lu |= h4 && bus.is_load_s4;
    end
    lu &= bus.valid_s3;
    exp_stall = lu || bus.hold_ext;
    exp_bubble = lu && !bus.hold_ext;
  endtask
  task automatic advance();
    logic [BITS-1:0] v;
    bit fw, h4;
    expect_now();
    if (rst) begin
      m_hold = 0; m_lu = 0; m_fc = 0;
      for (int k = 0; k < NS; k++) m_cv[k] = 0;
    end else begin
      if (bus.cnt_clr) begin
        m_lu = 0; m_fc = 0;
      end else begin
        if (exp_bubble) m_lu = (m_lu == CMAX) ? CMAX : m_lu + 1;
        if (bus.valid_s3 && !exp_stall && exp_any) m_fc = (m_fc == CMAX) ? CMAX : m_fc + 1;
      end
      if (!m_hold && bus.hold_ext) begin
        for (int k = 0; k < NS; k++) begin
          src_eval(k, v, fw, h4);
          m_cv[k] = !(h4 && bus.is_load_s4); m_cd[k] = v; m_cf[k] = fw;
        end
        m_hold = 1;
      end else if (m_hold && !bus.hold_ext) begin
        m_hold = 0;
        for (int k = 0; k < NS; k++) m_cv[k] = 0;
      end
    end
  endtask
  task automatic step();
    advance();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    idle(); rst = 1; set_src(0, 5'd5, 32'h1234);
    @(negedge clk); step(); step();
    rst = 0;
    @(negedge clk);
    n_cmp++; if (bus.load_use_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_lu got %0d want 0", bus.load_use_cnt); end
    n_cmp++; if (bus.fwd_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_fc got %0d want 0", bus.fwd_cnt); end
    n_cmp++; if (bus.stall_s3 !== 1'b0 || bus.bubble_s4 !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b%b want 00", bus.stall_s3, bus.bubble_s4); end
    n_cmp++; if (bus.src_data_fwd[31:0] !== 32'h1234) begin n_bad++; $display("FAIL reset_fwd got %h want 00001234", bus.src_data_fwd[31:0]); end
    step();
  endtask
  task automatic test_s4_alu();
    idle(); bus.valid_s3 = 1; set_src(0, 5'd5, 32'h1); s4(1, 0, 5'd5, 32'hAAAA0001);
    @(negedge clk);
    n_cmp++; if (bus.src_data_fwd[31:0] !== 32'hAAAA0001) begin n_bad++; $display("FAIL s4_fwd got %h want aaaa0001", bus.src_data_fwd[31:0]); end
    n_cmp++; if (bus.stall_s3 !== 1'b0) begin n_bad++; $display("FAIL s4_stall got %b want 0", bus.stall_s3); end
    step(); idle();
    @(negedge clk);
    n_cmp++; if (bus.fwd_cnt !== 4'd1) begin n_bad++; $display("FAIL s4_fwd_cnt got %0d want 1", bus.fwd_cnt); end
    step();
  endtask
  task automatic test_priority();
    idle(); bus.valid_s3 = 1; set_src(1, 5'd7, 32'h11); s4(1, 0, 5'd7, 32'h44); s5(1, 5'd7, 32'h55);
    @(negedge clk);
    n_cmp++; if (bus.src_data_fwd[63:32] !== 32'h44) begin n_bad++; $display("FAIL prio_s4 got %h want 44", bus.src_data_fwd[63:32]); end
    bus.valid_s4 = 0; #1;
    n_cmp++; if (bus.src_data_fwd[63:32] !== 32'h55) begin n_bad++; $display("FAIL prio_s5 got %h want 55", bus.src_data_fwd[63:32]); end
    step();
  endtask
  task automatic test_r0();
    idle(); bus.valid_s3 = 1; set_src(0, 5'd0, 32'h0); s4(1, 0, 5'd0, 32'hDEADBEEF); s5(1, 5'd0, 32'hCAFE);
    @(negedge clk);
    n_cmp++; if (bus.src_data_fwd[31:0] !== 32'h0) begin n_bad++; $display("FAIL r0_fwd got %h want 0", bus.src_data_fwd[31:0]); end
    step();
  endtask
  task automatic test_load_use();
    idle(); bus.cnt_clr = 1;
    @(negedge clk); step();
    idle(); bus.valid_s3 = 1; set_src(0, 5'd3, 32'h5); s4(1, 1, 5'd3, 32'h1000);
    @(negedge clk);
    n_cmp++; if (bus.stall_s3 !== 1'b1 || bus.bubble_s4 !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %b%b want 11", bus.stall_s3, bus.bubble_s4); end
    step();
    bus.valid_s4 = 0; s5(1, 5'd3, 32'h77);
    @(negedge clk);
    n_cmp++; if (bus.load_use_cnt !== 4'd1) begin n_bad++; $display("FAIL lu_cnt got %0d want 1", bus.load_use_cnt); end
    n_cmp++; if (bus.src_data_fwd[31:0] !== 32'h77) begin n_bad++; $display("FAIL lu_s5 got %h want 77", bus.src_data_fwd[31:0]); end
    n_cmp++; if (bus.stall_s3 !== 1'b0) begin n_bad++; $display("FAIL lu_release got %b want 0", bus.stall_s3); end
    step();
  endtask
  task automatic test_hold();
    idle(); bus.valid_s3 = 1; set_src(0, 5'd9, 32'h9); s4(1, 0, 5'd9, 32'h99); bus.hold_ext = 1;
    @(negedge clk);
    n_cmp++; if (bus.stall_s3 !== 1'b1 || bus.bubble_s4 !== 1'b0) begin n_bad++; $display("FAIL hold_stall got %b%b want 10", bus.stall_s3, bus.bubble_s4); end
    step();
    bus.valid_s4 = 0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.src_data_fwd[31:0] !== 32'h99) begin n_bad++; $display("FAIL hold_cap%0d got %h want 99", i, bus.src_data_fwd[31:0]); end
      step();
    end
    bus.hold_ext = 0;
    @(negedge clk);
    n_cmp++; if (bus.src_data_fwd[31:0] !== 32'h99 || bus.stall_s3 !== 1'b0) begin n_bad++; $display("FAIL hold_fall got %h/%b want 99/0", bus.src_data_fwd[31:0], bus.stall_s3); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.src_data_fwd[31:0] !== 32'h9) begin n_bad++; $display("FAIL hold_after got %h want 9", bus.src_data_fwd[31:0]); end
    step();
    idle(); bus.valid_s3 = 1; set_src(0, 5'd9, 32'h9); s4(1, 0, 5'd9, 32'h99); bus.hold_ext = 1;
    @(negedge clk); step();
    bus.valid_s4 = 0;
    @(negedge clk); step();
    rst = 1;
    @(negedge clk); step();
    rst = 0;
    @(negedge clk);
    n_cmp++; if (bus.src_data_fwd[31:0] !== 32'h9) begin n_bad++; $display("FAIL hold_rst got %h want 9", bus.src_data_fwd[31:0]); end
    n_cmp++; if (bus.load_use_cnt !== 4'd0 || bus.fwd_cnt !== 4'd0) begin n_bad++; $display("FAIL hold_rst_cnt got %0d/%0d want 0/0", bus.load_use_cnt, bus.fwd_cnt); end
    step();
  endtask
  task automatic test_saturation();
    idle(); bus.valid_s3 = 1; set_src(0, 5'd3, 32'h5); s4(1, 1, 5'd3, 32'h2000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); step();
    end
    @(negedge clk);
    n_cmp++; if (bus.load_use_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_lu got %0d want 15", bus.load_use_cnt); end
    bus.cnt_clr = 1;
    step();
    bus.cnt_clr = 0; bus.valid_s4 = 0;
    @(negedge clk);
    n_cmp++; if (bus.load_use_cnt !== 4'd0) begin n_bad++; $display("FAIL sat_clr got %0d want 0", bus.load_use_cnt); end
    step();
  endtask
  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.cnt_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) bus.hold_ext = ~bus.hold_ext;
      bus.valid_s3 = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NS; k++) begin
        bus.src_used_s3[k] = ($urandom_range(0, 3) != 0);
        bus.src_addr_s3[k*AW +: AW] = AW'($urandom_range(0, 3));
        bus.src_data_s3[k*BITS +: BITS] = $urandom;
      end
      s4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, 3)), $urandom);
      bus.rw_s4 = ($urandom_range(0, 3) != 0);
      s5(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom);
      bus.rw_s5 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      expect_now();
      n_cmp++; if (bus.src_data_fwd !== exp_fwd) begin n_bad++; $display("FAIL rnd_fwd c%0d got %h want %h", c, bus.src_data_fwd, exp_fwd); end
      n_cmp++; if (bus.stall_s3 !== exp_stall || bus.bubble_s4 !== exp_bubble) begin n_bad++; $display("FAIL rnd_stall c%0d got %b%b want %b%b", c, bus.stall_s3, bus.bubble_s4, exp_stall, exp_bubble); end
      n_cmp++; if (bus.load_use_cnt !== CW'(m_lu) || bus.fwd_cnt !== CW'(m_fc)) begin n_bad++; $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", c, bus.load_use_cnt, bus.fwd_cnt, m_lu, m_fc); end
      step();
    end
  endtask
  initial begin
    m_hold = 0; m_lu = 0; m_fc = 0;
    for (int k = 0; k < NS; k++) begin m_cv[k] = 0; m_cf[k] = 0; m_cd[k] = '0; end
    test_reset();
    test_s4_alu();
    test_priority();
    test_r0();
    test_load_use();
    test_hold();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
